// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator control FSM with add/sub/mul datapath and a restoring divider.
// Define CALC_REMAINDER_EN to expose the divide remainder on rem_val.
module calc_ctrl #(
  parameter int MAX_DIGITS = 4,
  parameter int OP_W       = 14,
  parameter int RES_W      = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_flag,
  input  logic [3:0]       key_data,
  output logic [RES_W-1:0] disp_val,
  output logic             disp_neg,
  output logic             err,
  output logic             busy,
  output logic [2:0]       state
`ifdef CALC_REMAINDER_EN
  ,
  output logic [OP_W-1:0]  rem_val
`endif
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int DCNT_W = $clog2(OP_W);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam logic [RES_W-1:0] CHAIN_LIM = RES_W'(10 ** MAX_DIGITS);

  state_t            cur_state;
  logic [OP_W-1:0]   a, b, div_q, div_r;
  logic [CNT_W-1:0]  cnt;
  logic [DCNT_W-1:0] div_cnt;
  logic [1:0]        op;
  logic [RES_W-1:0]  res;
  logic              neg;
`ifdef CALC_REMAINDER_EN
  logic [OP_W-1:0]   rem;
  assign rem_val = rem;
`endif

  logic             is_digit, is_op, is_eq, is_clr, cnt_room, a_ge_b;
  logic [1:0]       key_op;
  logic [OP_W-1:0]  digit, a_acc, b_acc, diff;
  logic [RES_W-1:0] calc_res;

  assign is_digit = (key_data <= 4'd9);
  assign is_op    = (key_data >= 4'd10) && (key_data <= 4'd13);
  assign is_eq    = (key_data == 4'd14);
  assign is_clr   = (key_data == 4'd15);
  assign key_op   = 2'(key_data - 4'd10);
  assign digit    = OP_W'(key_data);
  assign cnt_room = (cnt < CNT_W'(MAX_DIGITS));
  assign a_acc    = a * OP_W'(10) + digit;
  assign b_acc    = b * OP_W'(10) + digit;
  assign a_ge_b   = (a >= b);
  assign diff     = a_ge_b ? (a - b) : (b - a);

  always_comb begin
    calc_res = RES_W'(a) * RES_W'(b);
    if (op == OP_ADD)
      calc_res = RES_W'(a) + RES_W'(b);
    else if (op == OP_SUB)
      calc_res = RES_W'(diff);
  end

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  logic [OP_W:0]   r_sh;
  logic            r_ge;
  logic [OP_W-1:0] r_next, q_next;

  assign r_sh   = {div_r, div_q[OP_W-1]};
  assign r_ge   = (r_sh >= {1'b0, b});
  assign r_next = r_ge ? OP_W'(r_sh - {1'b0, b}) : r_sh[OP_W-1:0];
  assign q_next = {div_q[OP_W-2:0], r_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_A;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      op        <= '0;
      res       <= '0;
      neg       <= 1'b0;
      div_q     <= '0;
      div_r     <= '0;
      div_cnt   <= '0;
      disp_val  <= '0;
      disp_neg  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
`ifdef CALC_REMAINDER_EN
      rem       <= '0;
`endif
    end else if (key_flag && is_clr) begin
      cur_state <= S_A;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      op        <= '0;
      res       <= '0;
      neg       <= 1'b0;
      div_q     <= '0;
      div_r     <= '0;
      div_cnt   <= '0;
      disp_val  <= '0;
      disp_neg  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
`ifdef CALC_REMAINDER_EN
      rem       <= '0;
`endif
    end else begin
      case (cur_state)
        S_A: if (key_flag) begin
          if (is_digit && cnt_room) begin
            a        <= a_acc;
            cnt      <= cnt + CNT_W'(1);
            disp_val <= RES_W'(a_acc);
          end else if (is_op) begin
            op        <= key_op;
            cur_state <= S_OP;
          end
        end
        S_OP: if (key_flag) begin
          if (is_digit) begin
            b         <= digit;
            cnt       <= CNT_W'(1);
            disp_val  <= RES_W'(digit);
            cur_state <= S_B;
          end else if (is_op) begin
            op <= key_op;
          end
        end
        S_B: if (key_flag) begin
          if (is_digit && cnt_room) begin
            b        <= b_acc;
            cnt      <= cnt + CNT_W'(1);
            disp_val <= RES_W'(b_acc);
          end else if (is_eq) begin
            if (op != OP_DIV) begin
              res       <= calc_res;
              disp_val  <= calc_res;
              neg       <= (op == OP_SUB) && !a_ge_b;
              disp_neg  <= (op == OP_SUB) && !a_ge_b;
              cur_state <= S_RES;
`ifdef CALC_REMAINDER_EN
              rem       <= '0;
`endif
            end else if (b == '0) begin
              err       <= 1'b1;
              disp_val  <= '0;
              cur_state <= S_ERR;
            end else begin
              div_q     <= a;
              div_r     <= '0;
              div_cnt   <= '0;
              neg       <= 1'b0;
              busy      <= 1'b1;
              cur_state <= S_CALC;
            end
          end
        end
        // Keys are ignored here; only clear (handled above) can interrupt the divide.
        S_CALC: begin
          div_q   <= q_next;
          div_r   <= r_next;
          div_cnt <= div_cnt + DCNT_W'(1);
          if (div_cnt == DCNT_W'(OP_W - 1)) begin
            res       <= RES_W'(q_next);
            disp_val  <= RES_W'(q_next);
            disp_neg  <= 1'b0;
            busy      <= 1'b0;
            cur_state <= S_RES;
`ifdef CALC_REMAINDER_EN
            rem       <= r_next;
`endif
          end
        end
        S_RES: if (key_flag) begin
          if (is_digit) begin
            a         <= digit;
            cnt       <= CNT_W'(1);
            neg       <= 1'b0;
            disp_neg  <= 1'b0;
            disp_val  <= RES_W'(digit);
            cur_state <= S_A;
`ifdef CALC_REMAINDER_EN
            rem       <= '0;
`endif
          end else if (is_op && !neg && (res < CHAIN_LIM)) begin
            a         <= OP_W'(res);
            op        <= key_op;
            cur_state <= S_OP;
`ifdef CALC_REMAINDER_EN
            rem       <= '0;
`endif
          end
        end
        S_ERR: begin
        end
        default: cur_state <= S_A;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: scoreboard bench for calc_ctrl; directed calculator sequences followed by
// random key streams checked against a decimal-arithmetic reference model.
module tb_calc_ctrl;

   localparam int MAX_DIGITS = 4;
   localparam int OP_W       = 14;
   localparam int RES_W      = 28;
   localparam int LIMIT      = 10 ** MAX_DIGITS;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             key_flag;
   logic [3:0]       key_data;
   logic [RES_W-1:0] disp_val;
   logic             disp_neg;
   logic             err;
   logic             busy;
   logic [2:0]       state;
`ifdef CALC_REMAINDER_EN
   logic [OP_W-1:0]  rem_val;
`endif

   calc_ctrl #(.MAX_DIGITS(MAX_DIGITS), .OP_W(OP_W), .RES_W(RES_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_flag(key_flag),
      .key_data(key_data),
      .disp_val(disp_val),
      .disp_neg(disp_neg),
      .err(err),
      .busy(busy),
      .state(state)
`ifdef CALC_REMAINDER_EN
      ,
      .rem_val(rem_val)
`endif
   );

   always #5 clk = ~clk;

   typedef enum int {M_A = 0, M_OP = 1, M_B = 2, M_CALC = 3, M_RES = 4, M_ERR = 5} mode_t;

   typedef struct {
      logic [RES_W-1:0] val;
      logic             neg;
      logic             err;
      logic             busy;
      logic [2:0]       st;
      logic [OP_W-1:0]  rem;
      bit               chk_rem;
   } exp_t;

   exp_t exp_q[$];
   exp_t done_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Reference calculator: plain decimal arithmetic on integers
   mode_t m_mode;
   int    m_a, m_b, m_res, m_rem, m_digits, m_op;
   bit    m_neg;
   int    m_pend_q, m_pend_r;

   function automatic exp_t snapshot();
      exp_t e;
      e.st   = 3'(int'(m_mode));
      e.neg  = (m_mode == M_RES) && m_neg;
      e.err  = (m_mode == M_ERR);
      e.busy = (m_mode == M_CALC);
      e.rem  = OP_W'(m_rem);
      e.chk_rem = (m_mode == M_RES);
      case (m_mode)
         M_A, M_OP:   e.val = RES_W'(m_a);
         M_B, M_CALC: e.val = RES_W'(m_b);
         M_RES:       e.val = RES_W'(m_res);
         default:     e.val = '0;
      endcase
      return e;
   endfunction

   function automatic void modelReset();
      m_mode = M_A;
      m_a = 0; m_b = 0; m_res = 0; m_rem = 0; m_digits = 0; m_op = 10;
      m_neg = 1'b0;
      done_q.delete();
   endfunction

   function automatic void modelEvaluate();
      if (m_op == 13) begin
         if (m_b == 0) begin
            m_mode = M_ERR;
         end else begin
            exp_t d;
            m_mode   = M_CALC;
            m_pend_q = m_a / m_b;
            m_pend_r = m_a % m_b;
            d.val = RES_W'(m_pend_q); d.neg = 1'b0; d.err = 1'b0; d.busy = 1'b0;
            d.st = 3'd4; d.rem = OP_W'(m_pend_r); d.chk_rem = 1'b1;
            done_q.push_back(d);
         end
      end else begin
         m_neg = 1'b0;
         m_rem = 0;
         if (m_op == 10) m_res = m_a + m_b;
         else if (m_op == 12) m_res = m_a * m_b;
         else if (m_a >= m_b) m_res = m_a - m_b;
         else begin
            m_res = m_b - m_a;
            m_neg = 1'b1;
         end
         m_mode = M_RES;
      end
   endfunction

   function automatic void modelKey(input int k);
      if (k == 15) begin
         modelReset();
      end else begin
         case (m_mode)
            M_A: begin
               if (k <= 9 && m_digits < MAX_DIGITS) begin
                  m_a = m_a * 10 + k;
                  m_digits++;
               end else if (k >= 10 && k <= 13) begin
                  m_op = k;
                  m_mode = M_OP;
               end
            end
            M_OP: begin
               if (k <= 9) begin
                  m_b = k; m_digits = 1; m_mode = M_B;
               end else if (k <= 13) begin
                  m_op = k;
               end
            end
            M_B: begin
               if (k <= 9 && m_digits < MAX_DIGITS) begin
                  m_b = m_b * 10 + k;
                  m_digits++;
               end else if (k == 14) begin
                  modelEvaluate();
               end
            end
            M_RES: begin
               if (k <= 9) begin
                  m_a = k; m_digits = 1; m_neg = 1'b0; m_rem = 0; m_mode = M_A;
               end else if (k <= 13 && !m_neg && m_res < LIMIT) begin
                  m_a = m_res; m_op = k; m_rem = 0; m_mode = M_OP;
               end
            end
            default: ;
         endcase
      end
      exp_q.push_back(snapshot());
   endfunction

   function automatic void modelDivideDone();
      m_mode = M_RES;
      m_res  = m_pend_q;
      m_rem  = m_pend_r;
      m_neg  = 1'b0;
   endfunction

   task automatic checkOutput(input exp_t e, input string tag);
      bit bad;
      compared++;
      bad = (disp_val !== e.val) || (disp_neg !== e.neg) || (err !== e.err) ||
            (busy !== e.busy) || (state !== e.st);
`ifdef CALC_REMAINDER_EN
      if (e.chk_rem && rem_val !== e.rem) bad = 1'b1;
`endif
      if (bad) begin
         mismatched++;
         $display("[TB] FAIL %s @%0t: got val=%0d neg=%0b err=%0b busy=%0b state=%0d, required val=%0d neg=%0b err=%0b busy=%0b state=%0d rem=%0d",
                  tag, $time, disp_val, disp_neg, err, busy, state, e.val, e.neg, e.err, e.busy, e.st, e.rem);
      end
   endtask

   // Monitor: one expectation per sampled key, plus one per divide completion (busy falling)
   logic key_seen;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) key_seen <= 1'b0;
      else        key_seen <= key_flag;
   end

   bit rst_checked = 1'b0;
   bit prev_busy   = 1'b0;
   int busy_len    = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         if (!rst_checked && exp_q.size() > 0) checkOutput(exp_q.pop_front(), "reset");
         rst_checked = 1'b1;
         busy_len    = 0;
         prev_busy   = 1'b0;
      end else begin
         rst_checked = 1'b0;
         if (key_seen) begin
            if (exp_q.size() == 0) begin
               compared++; mismatched++;
               $display("[TB] FAIL key_no_expectation @%0t: got a sampled key, required a queued expectation", $time);
            end else begin
               checkOutput(exp_q.pop_front(), "key");
            end
         end else if (prev_busy && !busy) begin
            compared++;
            if (busy_len != OP_W) begin
               mismatched++;
               $display("[TB] FAIL busy_length: got %0d cycles, required %0d", busy_len, OP_W);
            end
            if (done_q.size() == 0) begin
               compared++; mismatched++;
               $display("[TB] FAIL divide_no_expectation @%0t: got busy fall, required a pending divide", $time);
            end else begin
               checkOutput(done_q.pop_front(), "divide");
            end
         end
         busy_len  = busy ? busy_len + 1 : 0;
         prev_busy = busy;
      end
   end

   task automatic applyStimulus(input int k);
      modelKey(k);
      @(posedge clk); #1;
      key_flag = 1'b1;
      key_data = 4'(k);
      @(posedge clk); #1;
      key_flag = 1'b0;
   endtask

   task automatic applyBurst(input int k0, input int k1, input int k2);
      modelKey(k0); modelKey(k1); modelKey(k2);
      @(posedge clk); #1;
      key_flag = 1'b1; key_data = 4'(k0);
      @(posedge clk); #1;
      key_data = 4'(k1);
      @(posedge clk); #1;
      key_data = 4'(k2);
      @(posedge clk); #1;
      key_flag = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < OP_W + 4) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         compared++; mismatched++;
         $display("[TB] FAIL busy_timeout: got busy=1 after %0d cycles, required 0", n);
         applyStimulus(15);
      end else begin
         modelDivideDone();
      end
   endtask

   task automatic applySeq(input string s);
      for (int i = 0; i < s.len(); i++) begin
         int k;
         case (s[i])
            "+":     k = 10;
            "-":     k = 11;
            "*":     k = 12;
            "/":     k = 13;
            "=":     k = 14;
            "C":     k = 15;
            default: k = int'(s[i]) - 48;
         endcase
         applyStimulus(k);
         if (m_mode == M_CALC) waitIdle();
      end
   endtask

   // During a divide, either poke an ignored key, abort with clear, or just wait it out
   task automatic finishDivide();
      int pick = $urandom_range(0, 3);
      if (pick == 0) begin
         repeat ($urandom_range(0, 8)) @(posedge clk);
         applyStimulus($urandom_range(0, 14));
      end else if (pick == 1) begin
         repeat ($urandom_range(0, 8)) @(posedge clk);
         applyStimulus(15);
         return;
      end
      waitIdle();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion, required $finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      key_flag = 1'b0;
      key_data = 4'd0;
      modelReset();
      exp_q.push_back(snapshot());
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      applySeq("1+9=");
      applySeq("9-1=");
      applySeq("1-9=");
      applySeq("9*1=");
      applySeq("9/1=");
      applySeq("99/4=");
      applySeq("7/0=5C");
      applySeq("12345");
      applySeq("C2+3=*4=");
      applySeq("C");
      applyBurst(5, 6, 7);
      applySeq("+8=");

      // Clear in the middle of a divide
      applySeq("99/7");
      applyStimulus(14);
      repeat (4) @(posedge clk);
      applyStimulus(15);
      repeat (3) @(posedge clk);

      // Asynchronous reset in the middle of operand entry
      applySeq("12");
      @(posedge clk); #1;
      rst_n = 1'b0;
      modelReset();
      exp_q.delete();
      exp_q.push_back(snapshot());
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         int r = $urandom_range(0, 99);
         int k;
         if (r < 55)      k = $urandom_range(0, 9);
         else if (r < 75) k = $urandom_range(10, 13);
         else if (r < 95) k = 14;
         else             k = 15;
         applyStimulus(k);
         if (m_mode == M_CALC) finishDivide();
      end

      repeat (5) @(posedge clk);
      compared++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL leftover_expectations: got %0d key / %0d divide pending, required 0 / 0",
                  exp_q.size(), done_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
